// File: rtl/noise_gate.sv
// Sample-rate noise gate: magnitude vs. threshold drives an attack/hold/release
// gain envelope, and the envelope scales each sample before the overdrive stage.
module noise_gate #(
    parameter int fxp_size     = 16,
    parameter int gain_bits    = 8,
    parameter int attack_step  = 32,
    parameter int release_step = 4,
    parameter int hold_w       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic signed [fxp_size-1:0] i_sample,
    input  logic        [fxp_size-1:0] i_threshold,
    input  logic        [hold_w-1:0]   i_hold,
    output logic                       o_valid,
    output logic signed [fxp_size-1:0] o_sample,
    output logic                       o_open
);

    // Gain register holds 0..unity inclusive, so it needs one bit above the fraction.
    localparam int GW = gain_bits + 1;
    // Product width with headroom for the zero-extended gain operand.
    localparam int PW = fxp_size + gain_bits + 2;

    localparam logic [GW-1:0] UNITY       = GW'(1) << gain_bits;
    localparam logic [GW:0]   ATTACK_INC  = (GW + 1)'(attack_step);
    localparam logic [GW-1:0] RELEASE_DEC = GW'(release_step);

    typedef enum logic [2:0] {
        S_CLOSED,
        S_ATTACK,
        S_OPEN,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [GW-1:0]      g;
    logic [GW-1:0]      g_next;
    logic [hold_w-1:0]  cnt;
    logic [hold_w-1:0]  cnt_next;

    logic [fxp_size-1:0] mag;
    logic                above;
    logic [GW:0]         g_sum;
    logic [GW-1:0]       g_up;
    logic [GW-1:0]       g_dn;
    logic signed [PW-1:0] prod;

    // Absolute value of the sample; the most negative code saturates to the most positive.
    always_comb begin
        if (i_sample == {1'b1, {(fxp_size-1){1'b0}}}) begin
            mag = {1'b0, {(fxp_size-1){1'b1}}};
        end else if (i_sample[fxp_size-1]) begin
            mag = -i_sample;
        end else begin
            mag = i_sample;
        end
    end

    assign above = (mag >= i_threshold);

    // Saturating envelope steps: attack clamps at unity, release clamps at zero.
    assign g_sum = {1'b0, g} + ATTACK_INC;
    assign g_up  = (g_sum >= {1'b0, UNITY}) ? UNITY : g_sum[GW-1:0];
    assign g_dn  = (g <= RELEASE_DEC) ? '0 : (g - RELEASE_DEC);

    // Scale by the gain in effect before this sample's envelope update.
    assign prod = PW'(i_sample) * $signed(PW'({1'b0, g}));

    // Envelope state machine: next state, gain and hold count for the current sample.
    always_comb begin
        state_next = state;
        g_next     = g;
        cnt_next   = cnt;
        case (state)
            S_CLOSED: begin
                if (above) begin
                    state_next = S_ATTACK;
                    g_next     = g_up;
                end else begin
                    g_next = '0;
                end
            end
            S_ATTACK: begin
                g_next = g_up;
                if (g_up == UNITY) begin
                    state_next = S_OPEN;
                end
            end
            S_OPEN: begin
                g_next = UNITY;
                if (!above) begin
                    state_next = S_HOLD;
                    cnt_next   = i_hold;
                end
            end
            S_HOLD: begin
                if (above) begin
                    state_next = S_OPEN;
                end else if (cnt == '0) begin
                    state_next = S_RELEASE;
                end else begin
                    cnt_next = cnt - hold_w'(1);
                end
            end
            S_RELEASE: begin
                if (above) begin
                    state_next = S_ATTACK;
                    g_next     = g_up;
                end else begin
                    g_next = g_dn;
                    if (g_dn == '0) begin
                        state_next = S_CLOSED;
                    end
                end
            end
            default: begin
                state_next = S_CLOSED;
                g_next     = '0;
                cnt_next   = '0;
            end
        endcase
    end

    // State, envelope and output registers advance together, only on valid samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_CLOSED;
            g        <= '0;
            cnt      <= '0;
            o_valid  <= 1'b0;
            o_sample <= '0;
            o_open   <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                state    <= state_next;
                g        <= g_next;
                cnt      <= cnt_next;
                o_sample <= fxp_size'(prod >>> gain_bits);
                o_open   <= (state_next == S_OPEN) || (state_next == S_HOLD);
            end
        end
    end

endmodule

// File: tb/tb_noise_gate.sv
// Directed testbench for noise_gate with hand-computed expected outputs.
module tb_noise_gate;

    logic               clk;
    logic               rst;
    logic               i_valid;
    logic signed [15:0] i_sample;
    logic        [15:0] i_threshold;
    logic        [15:0] i_hold;
    logic               o_valid;
    logic signed [15:0] o_sample;
    logic               o_open;

    int vectors = 0;
    int errors  = 0;

    noise_gate dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_sample    (i_sample),
        .i_threshold (i_threshold),
        .i_hold      (i_hold),
        .o_valid     (o_valid),
        .o_sample    (o_sample),
        .o_open      (o_open)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one sample for a single clock; returns on the following negedge.
    task automatic drive(input logic signed [15:0] s, input logic [15:0] thr, input logic [15:0] hold);
        i_sample    = s;
        i_threshold = thr;
        i_hold      = hold;
        i_valid     = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int exp_a[3] = '{0, 250, 500};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (o_valid !== 1'b0 || o_sample !== 16'sd0 || o_open !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got valid=%b sample=%0d open=%b want 0/0/0", o_valid, o_sample, o_open);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(16'sd2000, 16'd1000, 16'd0);
            vectors++;
            if (o_sample !== 16'(exp_a[i])) begin
                errors++;
                $display("[TB] FAIL pre_reset_attack[%0d]: got %0d want %0d", i, o_sample, exp_a[i]);
            end
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (o_valid !== 1'b0 || o_sample !== 16'sd0 || o_open !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got valid=%b sample=%0d open=%b want 0/0/0", o_valid, o_sample, o_open);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(16'sd2000, 16'd1000, 16'd0);
        vectors++;
        if (o_valid !== 1'b1 || o_sample !== 16'sd0 || o_open !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_sample: got valid=%b sample=%0d open=%b want 1/0/0", o_valid, o_sample, o_open);
        end
        pulse_reset();
    endtask

    task automatic test_closed();
        for (int i = 0; i < 20; i++) begin
            drive(16'sd500, 16'd1000, 16'd0);
            vectors++;
            if (o_valid !== 1'b1 || o_sample !== 16'sd0 || o_open !== 1'b0) begin
                errors++;
                $display("[TB] FAIL closed[%0d]: got valid=%b sample=%0d open=%b want 1/0/0", i, o_valid, o_sample, o_open);
            end
        end
    endtask

    task automatic test_attack();
        int exp_s[12] = '{0, 250, 500, 750, 1000, 1250, 1500, 1750, 2000, 2000, 2000, 2000};
        for (int i = 0; i < 12; i++) begin
            drive(16'sd2000, 16'd1000, 16'd0);
            vectors++;
            if (o_sample !== 16'(exp_s[i]) || o_open !== (i >= 7)) begin
                errors++;
                $display("[TB] FAIL attack[%0d]: got sample=%0d open=%b want %0d/%b", i, o_sample, o_open, exp_s[i], (i >= 7));
            end
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (o_valid !== 1'b0 || o_sample !== 16'sd2000 || o_open !== 1'b1) begin
                errors++;
                $display("[TB] FAIL idle[%0d]: got valid=%b sample=%0d open=%b want 0/2000/1", i, o_valid, o_sample, o_open);
            end
        end
    endtask

    task automatic test_hold_release();
        int   exp_s[10] = '{100, 100, 100, 100, 100, 100, 98, 96, 95, 93};
        logic exp_o[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(16'sd100, 16'd1000, 16'd3);
            vectors++;
            if (o_sample !== 16'(exp_s[i]) || o_open !== exp_o[i]) begin
                errors++;
                $display("[TB] FAIL hold_release[%0d]: got sample=%0d open=%b want %0d/%b", i, o_sample, o_open, exp_s[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_release_to_attack();
        int   exp_s[5] = '{1000, 1250, 1500, 1750, 2000};
        logic exp_o[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 27; i++) begin
            drive(16'sd0, 16'd1000, 16'd3);
            vectors++;
            if (o_sample !== 16'sd0 || o_open !== 1'b0) begin
                errors++;
                $display("[TB] FAIL release_drain[%0d]: got sample=%0d open=%b want 0/0", i, o_sample, o_open);
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive(16'sd2000, 16'd1000, 16'd3);
            vectors++;
            if (o_sample !== 16'(exp_s[i]) || o_open !== exp_o[i]) begin
                errors++;
                $display("[TB] FAIL release_to_attack[%0d]: got sample=%0d open=%b want %0d/%b", i, o_sample, o_open, exp_s[i], exp_o[i]);
            end
        end
    endtask

    task automatic test_hold_reload();
        logic exp_o[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(16'sd100, 16'd1000, 16'd3);
            vectors++;
            if (o_sample !== 16'sd100 || o_open !== 1'b1) begin
                errors++;
                $display("[TB] FAIL hold_enter[%0d]: got sample=%0d open=%b want 100/1", i, o_sample, o_open);
            end
        end
        drive(16'sd2000, 16'd1000, 16'd3);
        vectors++;
        if (o_sample !== 16'sd2000 || o_open !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_reopen: got sample=%0d open=%b want 2000/1", o_sample, o_open);
        end
        for (int i = 0; i < 4; i++) begin
            drive(16'sd100, 16'd1000, 16'd2);
            vectors++;
            if (o_sample !== 16'sd100 || o_open !== exp_o[i]) begin
                errors++;
                $display("[TB] FAIL hold_reload[%0d]: got sample=%0d open=%b want 100/%b", i, o_sample, o_open, exp_o[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_s[10] = '{0, -4096, -8192, -12288, -16384, -20480, -24576, -28672, -32768, -32768};
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            drive(-16'sd32768, 16'd32767, 16'd3);
            vectors++;
            if (o_sample !== 16'(exp_s[i]) || o_open !== (i >= 7)) begin
                errors++;
                $display("[TB] FAIL saturation[%0d]: got sample=%0d open=%b want %0d/%b", i, o_sample, o_open, exp_s[i], (i >= 7));
            end
        end
    endtask

    task automatic test_negative_floor();
        int exp_s[2] = '{0, -126};
        pulse_reset();
        for (int i = 0; i < 2; i++) begin
            drive(-16'sd1001, 16'd1000, 16'd0);
            vectors++;
            if (o_sample !== 16'(exp_s[i])) begin
                errors++;
                $display("[TB] FAIL negative_floor[%0d]: got %0d want %0d", i, o_sample, exp_s[i]);
            end
        end
    endtask

    task automatic test_zero_threshold();
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            drive(16'sd0, 16'd0, 16'd0);
            vectors++;
            if (o_sample !== 16'sd0 || o_open !== (i >= 7)) begin
                errors++;
                $display("[TB] FAIL zero_threshold[%0d]: got sample=%0d open=%b want 0/%b", i, o_sample, o_open, (i >= 7));
            end
        end
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        rst         = 1'b1;
        i_valid     = 1'b0;
        i_sample    = '0;
        i_threshold = '0;
        i_hold      = '0;
        @(negedge clk);
        test_reset();
        test_closed();
        test_attack();
        test_idle();
        test_hold_release();
        test_release_to_attack();
        test_hold_reload();
        test_saturation();
        test_negative_floor();
        test_zero_threshold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
